// File: rtl/soc_pkg.sv
// rtl/soc_pkg.sv - shared widths, requester ids and helpers for the RAM arbiter
package soc_pkg;

  localparam int NREQ   = 3;
  localparam int ADDR_W = 19;
  localparam int DATA_W = 19;

  typedef enum logic [1:0] {
    REQ_IF  = 2'd0,
    REQ_LSU = 2'd1,
    REQ_DMA = 2'd2
  } req_id_e;

  // Successor of a requester id in the 0 -> 1 -> 2 -> 0 rotation.
  function automatic logic [1:0] next_id(input logic [1:0] id);
    return (id == 2'd2) ? 2'd0 : id + 2'd1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational 3-way rotating priority picker
module rr_pick
  import soc_pkg::*;
(
  input  logic [NREQ-1:0] valid_i,
  input  logic [1:0]      ptr_i,
  output logic [NREQ-1:0] grant_o,
  output logic [1:0]      winner_o
);

  // Scan ptr, ptr+1, ptr+2 (mod 3); the first valid requester wins.
  always_comb begin
    logic [1:0] cand;
    logic       found;
    grant_o  = '0;
    winner_o = 2'd0;
    found    = 1'b0;
    cand     = (ptr_i > 2'd2) ? 2'd0 : ptr_i;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && valid_i[cand]) begin
        grant_o[cand] = 1'b1;
        winner_o      = cand;
        found         = 1'b1;
      end
      cand = next_id(cand);
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin RAM arbiter with bounded lock and read response routing
module mem_arbiter
  import soc_pkg::*;
#(
  parameter int LOCK_MAX = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ-1:0]        req_write,
  input  logic [NREQ-1:0]        req_lock,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
  input  logic [NREQ*DATA_W-1:0] req_wdata,
  output logic [NREQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]      rsp_rdata,
  output logic                   mem_valid,
  output logic                   mem_write,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [DATA_W-1:0]      mem_wdata,
  input  logic [DATA_W-1:0]      mem_rdata
);

  // Last lock count value that still allows one more locked grant.
  localparam logic [3:0] LOCK_LAST = 4'(LOCK_MAX - 1);

  logic [1:0]      ptr_q, ptr_d;
  logic [3:0]      lock_cnt_q, lock_cnt_d;
  logic            rd_pend_q, rd_pend_d;
  logic [1:0]      rsp_id_q, rsp_id_d;

  logic [NREQ-1:0] pick_grant;
  logic [1:0]      pick_id;
  logic [NREQ-1:0] grant;
  logic            any_grant;

  rr_pick u_pick (
    .valid_i  (req_valid),
    .ptr_i    (ptr_q),
    .grant_o  (pick_grant),
    .winner_o (pick_id)
  );

  // Reset forces the grant off combinationally so nothing reaches the RAM.
  always_comb begin
    grant     = rst ? '0 : pick_grant;
    any_grant = |grant;
    req_ready = grant;
    mem_valid = any_grant;
  end

  // Steer the winner's command onto the RAM port; all-zero when idle.
  always_comb begin
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        mem_write = req_write[i];
        mem_addr  = req_addr[i*ADDR_W +: ADDR_W];
        mem_wdata = req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // Next pointer / lock count and read-pending bookkeeping.
  always_comb begin
    ptr_d      = ptr_q;
    lock_cnt_d = 4'd0;
    rd_pend_d  = 1'b0;
    rsp_id_d   = rsp_id_q;
    if (any_grant) begin
      if (req_lock[pick_id] && (lock_cnt_q < LOCK_LAST)) begin
        ptr_d      = pick_id;
        lock_cnt_d = lock_cnt_q + 4'd1;
      end else begin
        ptr_d      = next_id(pick_id);
      end
      if (!req_write[pick_id]) begin
        rd_pend_d = 1'b1;
        rsp_id_d  = pick_id;
      end
    end
  end

  // Arbitration state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q      <= 2'd0;
      lock_cnt_q <= 4'd0;
      rd_pend_q  <= 1'b0;
      rsp_id_q   <= 2'd0;
    end else begin
      ptr_q      <= ptr_d;
      lock_cnt_q <= lock_cnt_d;
      rd_pend_q  <= rd_pend_d;
      rsp_id_q   <= rsp_id_d;
    end
  end

  // Route the RAM's registered read data to whoever issued the read.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      rsp_valid[i] = rd_pend_q && (rsp_id_q == 2'(i));
    end
    rsp_rdata = mem_rdata;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed scoreboard bench for mem_arbiter
module tb_mem_arbiter;
  import soc_pkg::*;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ-1:0]        req_write;
  logic [NREQ-1:0]        req_lock;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ*DATA_W-1:0] req_wdata;
  logic [NREQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]      rsp_rdata;
  logic                   mem_valid;
  logic                   mem_write;
  logic [ADDR_W-1:0]      mem_addr;
  logic [DATA_W-1:0]      mem_wdata;
  logic [DATA_W-1:0]      mem_rdata;

  mem_arbiter #(.LOCK_MAX(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_lock  (req_lock),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .mem_valid (mem_valid),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  // RAM model: single port, registered read data.
  logic [DATA_W-1:0] ram [0:1023];
  always @(posedge clk) begin
    if (mem_valid) begin
      if (mem_write) ram[mem_addr[9:0]] <= mem_wdata;
      else           mem_rdata <= ram[mem_addr[9:0]];
    end
  end

  // Expected RAM contents as the stimulus intends them.
  logic [DATA_W-1:0] shadow [0:1023];

  typedef struct packed {
    logic [NREQ-1:0]   oh;
    logic [DATA_W-1:0] data;
  } exp_t;
  exp_t exp_q[$];

  int vectors = 0;
  int miscompares = 0;

  logic [NREQ-1:0]   v_valid, v_write, v_lock;
  logic              v_rst;
  logic [ADDR_W-1:0] v_addr  [NREQ];
  logic [DATA_W-1:0] v_wdata [NREQ];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One cycle: drive at negedge, sample 1ns later, score, predict next response.
  task automatic step(input int exp_g, input string tag);
    exp_t e;
    exp_t n;
    logic [NREQ-1:0] oh;
    @(negedge clk);
    rst       = v_rst;
    req_valid = v_valid;
    req_write = v_write;
    req_lock  = v_lock;
    for (int i = 0; i < NREQ; i++) begin
      req_addr[i*ADDR_W +: ADDR_W]  = v_addr[i];
      req_wdata[i*DATA_W +: DATA_W] = v_wdata[i];
    end
    #1;
    oh = (exp_g < 0) ? 3'b000 : 3'(1 << exp_g);
    check({tag, ".ready"}, 64'(req_ready), 64'(oh));
    check({tag, ".mem_valid"}, 64'(mem_valid), 64'(exp_g >= 0));
    if (exp_g >= 0) begin
      check({tag, ".mem_write"}, 64'(mem_write), 64'(v_write[exp_g]));
      check({tag, ".mem_addr"}, 64'(mem_addr), 64'(v_addr[exp_g]));
      check({tag, ".mem_wdata"}, 64'(mem_wdata), 64'(v_wdata[exp_g]));
    end else begin
      check({tag, ".mem_idle"}, 64'({mem_write, mem_addr, mem_wdata}), 64'd0);
    end
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    check({tag, ".rsp_valid"}, 64'(rsp_valid), 64'(e.oh));
    if (e.oh != 0) check({tag, ".rsp_rdata"}, 64'(rsp_rdata), 64'(e.data));
    n = '0;
    if (exp_g >= 0) begin
      if (v_write[exp_g]) begin
        shadow[v_addr[exp_g][9:0]] = v_wdata[exp_g];
      end else begin
        n.oh   = oh;
        n.data = shadow[v_addr[exp_g][9:0]];
      end
    end
    exp_q.push_back(n);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      ram[i]    = '0;
      shadow[i] = '0;
    end
    ram[10'h010] = 19'h1ABCD; shadow[10'h010] = 19'h1ABCD;
    ram[10'h030] = 19'h0F0F1; shadow[10'h030] = 19'h0F0F1;
    ram[10'h050] = 19'h7A5A5; shadow[10'h050] = 19'h7A5A5;
    mem_rdata = '0;

    v_valid = '0; v_write = '0; v_lock = '0; v_rst = 1'b0;
    v_addr[0]  = 19'h00030; v_addr[1]  = 19'h00010; v_addr[2]  = 19'h00050;
    v_wdata[0] = 19'h00111; v_wdata[1] = 19'h00222; v_wdata[2] = 19'h00333;

    rst = 1'b1; req_valid = '0; req_write = '0; req_lock = '0;
    req_addr = '0; req_wdata = '0;
    repeat (2) @(posedge clk);
    exp_q.push_back('0);

    // Reset state, held in reset with everyone requesting.
    v_rst = 1'b1; v_valid = 3'b111;
    step(-1, "reset");
    v_rst = 1'b0; v_valid = 3'b000;
    step(-1, "post_reset_idle");

    // Single LSU read of 0x00010.
    v_valid = 3'b010;
    step(1, "single_rd");
    v_valid = 3'b000;
    step(-1, "single_rsp");

    // Fairness from reset: continuous unlocked reads from all three.
    v_rst = 1'b1;
    step(-1, "fair_rst");
    v_rst = 1'b0; v_valid = 3'b111;
    step(0, "fair0"); step(1, "fair1"); step(2, "fair2");
    step(0, "fair3"); step(1, "fair4"); step(2, "fair5");

    // Fetch writes 0x12345 to 0x00100, DMA reads it back the next cycle.
    v_valid = 3'b001; v_write = 3'b001;
    v_addr[0] = 19'h00100; v_wdata[0] = 19'h12345;
    step(0, "wr_fetch");
    v_valid = 3'b100; v_write = 3'b000; v_addr[2] = 19'h00100;
    step(2, "rd_dma");
    v_valid = 3'b000;
    step(-1, "rd_dma_rsp");
    v_addr[0] = 19'h00030; v_addr[2] = 19'h00050;

    // Lock bound: LSU locked, pointer first moved onto LSU.
    v_valid = 3'b001;
    step(0, "lock_prep");
    v_valid = 3'b111; v_lock = 3'b010;
    step(1, "lock_l0"); step(1, "lock_l1"); step(1, "lock_l2"); step(1, "lock_l3");
    step(2, "lock_dma"); step(0, "lock_if"); step(1, "lock_l_again");

    // Idle for 5 cycles: pointer held on LSU, lock count cleared.
    v_valid = 3'b000; v_lock = 3'b000;
    for (int i = 0; i < 5; i++) step(-1, "idle");
    check("idle.ptr", 64'(dut.ptr_q), 64'd1);
    check("idle.lock_cnt", 64'(dut.lock_cnt_q), 64'd0);

    // Reset mid-operation: read accepted, then reset with all valid.
    v_valid = 3'b111;
    step(1, "mid_rd");
    v_rst = 1'b1;
    step(-1, "mid_rst");
    v_rst = 1'b0;
    step(0, "mid_release");
    v_valid = 3'b000;
    step(-1, "mid_final");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
